// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core: hh:mm:ss.cc up/down timebase with countdown expiry and a lap FIFO.
module stopwatch_lap_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 8,
    parameter int HOUR_MAX  = 99
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       mode_down,
    input  logic                       clear,
    input  logic                       load,
    input  logic [27:0]                load_value,
    input  logic                       lap_req,
    input  logic                       lap_flush,
    output logic [27:0]                timestamp,
    output logic                       tick,
    output logic                       reg_busy,
    output logic                       expired,
    output logic                       lap_valid,
    output logic [27:0]                lap_data,
    input  logic                       lap_ready,
    output logic [$clog2(LAP_DEPTH):0] lap_count,
    output logic                       lap_overflow
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int AW  = $clog2(LAP_DEPTH);
    localparam logic [6:0] HMAX = 7'(HOUR_MAX);

    logic [PW-1:0] presc;
    logic [6:0]    c, s, m, h;
    logic [6:0]    up_c, up_s, up_m, up_h, dn_c, dn_s, dn_m, dn_h;
    logic [6:0]    ld_c, ld_s, ld_m, ld_h;
    logic          c_wrap, s_wrap, m_wrap, c_zero, s_bor, m_bor;
    logic [27:0]   next_ts;

    assign tick = run && presc == PW'(DIV - 1);
    assign {h, m, s, c} = timestamp;

    always_comb begin
        c_wrap  = c == 7'd99;
        s_wrap  = c_wrap && s == 7'd59;
        m_wrap  = s_wrap && m == 7'd59;
        up_c    = c_wrap ? 7'd0 : c + 7'd1;
        up_s    = c_wrap ? (s == 7'd59 ? 7'd0 : s + 7'd1) : s;
        up_m    = s_wrap ? (m == 7'd59 ? 7'd0 : m + 7'd1) : m;
        up_h    = m_wrap ? (h == HMAX ? 7'd0 : h + 7'd1) : h;
        c_zero  = c == 7'd0;
        s_bor   = c_zero && s == 7'd0;
        m_bor   = s_bor && m == 7'd0;
        dn_c    = c_zero ? 7'd99 : c - 7'd1;
        dn_s    = c_zero ? (s == 7'd0 ? 7'd59 : s - 7'd1) : s;
        dn_m    = s_bor ? (m == 7'd0 ? 7'd59 : m - 7'd1) : m;
        dn_h    = m_bor ? h - 7'd1 : h;
        // a countdown parked at zero holds there instead of borrowing into 99:59:59.99
        next_ts = !mode_down ? {up_h, up_m, up_s, up_c} :
                  timestamp == 28'd0 ? 28'd0 : {dn_h, dn_m, dn_s, dn_c};
        ld_c    = load_value[6:0]   > 7'd99 ? 7'd99 : load_value[6:0];
        ld_s    = load_value[13:7]  > 7'd59 ? 7'd59 : load_value[13:7];
        ld_m    = load_value[20:14] > 7'd59 ? 7'd59 : load_value[20:14];
        ld_h    = load_value[27:21] > HMAX  ? HMAX  : load_value[27:21];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            timestamp <= '0;
            expired   <= 1'b0;
            reg_busy  <= 1'b0;
        end else if (clear) begin
            presc     <= '0;
            timestamp <= '0;
            expired   <= 1'b0;
            reg_busy  <= 1'b1;
        end else if (load) begin
            presc     <= '0;
            timestamp <= {ld_h, ld_m, ld_s, ld_c};
            expired   <= 1'b0;
            reg_busy  <= 1'b1;
        end else begin
            reg_busy <= tick && next_ts != timestamp;
            if (run)
                presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                timestamp <= next_ts;
                if (mode_down && next_ts == 28'd0)
                    expired <= 1'b1;
            end
        end
    end

    logic [27:0]   mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, push, pop;

    assign lap_valid = lap_count != '0;
    assign full      = lap_count == (AW + 1)'(LAP_DEPTH);
    assign pop       = lap_valid && lap_ready;
    assign push      = lap_req && (!full || pop);
    assign lap_data  = lap_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push && !lap_flush)
            mem[wr_ptr] <= timestamp;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset || lap_flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lap_count    <= '0;
            lap_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            lap_count <= lap_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (lap_req && !push)
                lap_overflow <= 1'b1;
        end
    end
endmodule
